// File: rtl/trigger_fifo_arbiter_if.sv
// Handshake bundle between the two trigger receivers, the arbiter and the trigger FIFO.
// Ports: req0/req1 valid/data/ready from the receivers, fifo valid/data/ready towards the FIFO.
interface trigger_fifo_arbiter_if;
  logic         req0_valid;
  logic [127:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic         req1_ready;
  logic         fifo_ready;
  logic         fifo_valid;
  logic [127:0] fifo_data;

  modport slave (
    input  req0_valid, req0_data,
    input  req1_valid, req1_data,
    input  fifo_ready,
    output req0_ready, req1_ready,
    output fifo_valid, fifo_data
  );

  modport master (
    output req0_valid, req0_data,
    output req1_valid, req1_data,
    output fifo_ready,
    input  req0_ready, req1_ready,
    input  fifo_valid, fifo_data
  );
endinterface

// File: rtl/trigger_fifo_arbiter.sv
// Round-robin arbiter sharing the trigger FIFO write port between the pulse and TTC receivers.
// Ports: clk/reset/reset_counters, bus (slave modport), state, grant_cnt0/1, stall_err.
module trigger_fifo_arbiter #(
  parameter logic [15:0] STALL_LIMIT = 16'd4000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         reset_counters,
  trigger_fifo_arbiter_if.slave        bus,
  output logic [2:0]                   state,
  output logic [31:0]                  grant_cnt0,
  output logic [31:0]                  grant_cnt1,
  output logic                         stall_err
);

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_SEND0 = 3'b010;
  localparam logic [2:0] S_SEND1 = 3'b100;

  logic [2:0]   state_q, state_d;
  logic         fifo_valid_q, fifo_valid_d;
  logic [127:0] fifo_data_q, fifo_data_d;
  logic         last_grant_q, last_grant_d;
  logic [31:0]  grant_cnt0_q, grant_cnt0_d;
  logic [31:0]  grant_cnt1_q, grant_cnt1_d;
  logic [15:0]  stall_cnt_q, stall_cnt_d;
  logic         stall_err_q, stall_err_d;

  logic is_idle;
  logic is_send;
  logic win0;
  logic win1;

  assign is_idle = (state_q == S_IDLE);
  assign is_send = (state_q == S_SEND0) ||
                   (state_q == S_SEND1);

  // On a tie the requester that did not win last time goes first.
  assign win0 = bus.req0_valid &
                (~bus.req1_valid | last_grant_q);
  assign win1 = bus.req1_valid &
                (~bus.req0_valid | ~last_grant_q);

  // Exact IDLE compare so a corrupted state never acks a word it will not latch.
  assign bus.req0_ready = is_idle & win0;
  assign bus.req1_ready = is_idle & win1;

  always_comb begin
    state_d      = state_q;
    fifo_valid_d = fifo_valid_q;
    fifo_data_d  = fifo_data_q;
    last_grant_d = last_grant_q;
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;

    unique case (1'b1)
      is_idle: begin
        stall_cnt_d = 16'd0;
        if (win0) begin
          fifo_data_d      = bus.req0_data;
          fifo_data_d[127] = 1'b0;
          fifo_valid_d     = 1'b1;
          last_grant_d     = 1'b0;
          grant_cnt0_d     = grant_cnt0_q + 32'd1;
          state_d          = S_SEND0;
        end else if (win1) begin
          fifo_data_d      = bus.req1_data;
          fifo_data_d[127] = 1'b1;
          fifo_valid_d     = 1'b1;
          last_grant_d     = 1'b1;
          grant_cnt1_d     = grant_cnt1_q + 32'd1;
          state_d          = S_SEND1;
        end else begin
          fifo_valid_d = 1'b0;
        end
      end
      is_send: begin
        if (bus.fifo_ready) begin
          fifo_valid_d = 1'b0;
          fifo_data_d  = 128'd0;
          stall_cnt_d  = 16'd0;
          state_d      = S_IDLE;
        end else begin
          if (stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
          // A limit of zero turns the watchdog off.
          if ((STALL_LIMIT != 16'd0) &&
              (stall_cnt_q == STALL_LIMIT - 16'd1))
            stall_err_d = 1'b1;
        end
      end
      default: begin
        state_d      = S_IDLE;
        fifo_valid_d = 1'b0;
        fifo_data_d  = 128'd0;
        stall_cnt_d  = 16'd0;
      end
    endcase

    // Clearing beats a grant in the same cycle.
    if (reset_counters) begin
      grant_cnt0_d = 32'd0;
      grant_cnt1_d = 32'd0;
      stall_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fifo_valid_q <= 1'b0;
      fifo_data_q  <= 128'd0;
      last_grant_q <= 1'b1;
      grant_cnt0_q <= 32'd0;
      grant_cnt1_q <= 32'd0;
      stall_cnt_q  <= 16'd0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_valid_q <= fifo_valid_d;
      fifo_data_q  <= fifo_data_d;
      last_grant_q <= last_grant_d;
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
    end
  end

  assign bus.fifo_valid = fifo_valid_q;
  assign bus.fifo_data  = fifo_data_q;
  assign state          = state_q;
  assign grant_cnt0     = grant_cnt0_q;
  assign grant_cnt1     = grant_cnt1_q;
  assign stall_err      = stall_err_q;

endmodule
